// File: rtl/calc_pkg.sv
// Shared opcodes, state encoding and default operand width for the calculator front end.
package calc_pkg;

  localparam int WIDTH_DEF = 4;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_LAND = 3'b100;
  localparam logic [2:0] OP_LOR  = 3'b101;
  localparam logic [2:0] OP_LT   = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_B  = 3'd1,
    ST_LOAD_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_HOLD    = 3'd4
  } state_t;

endpackage

// File: rtl/calc_operand_sequencer_if.sv
// Bundle of the input channel, function-unit operand/result wires and the output channel.
interface calc_operand_sequencer_if
  import calc_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int RES_WIDTH = 2 * WIDTH
);
  // Both channels use strict valid/ready: a beat transfers on a rising edge where
  // valid and ready are both high; the sender holds valid and data until then, and
  // ready never depends combinationally on valid.
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     data_in;
  logic [2:0]           op_in;

  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [2:0]           op;
  logic                 en;
  logic [RES_WIDTH-1:0] res_in;
  logic                 flag_in;

  logic                 out_valid;
  logic                 out_ready;
  logic [RES_WIDTH-1:0] res_out;
  logic                 flag_out;
  logic                 err;

  modport slave (
    input  in_valid, data_in, op_in, res_in, flag_in, out_ready,
    output in_ready, a, b, op, en, out_valid, res_out, flag_out, err
  );

  modport master (
    output in_valid, data_in, op_in, res_in, flag_in, out_ready,
    input  in_ready, a, b, op, en, out_valid, res_out, flag_out, err
  );

endinterface

// File: rtl/calc_operand_sequencer.sv
// Loads A, B and an opcode, enables the function units for a fixed settle time, then holds the result.
module calc_operand_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int RES_WIDTH   = 2 * WIDTH,
  parameter int EXEC_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  calc_operand_sequencer_if.slave  bus,
  output state_t                   state_dbg
);

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  state_t               state;
  logic [3:0]           cnt;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [2:0]           op_q;
  logic [RES_WIDTH-1:0] res_q;
  logic                 flag_q;
  logic                 err_q;

  // Handshake qualifiers and enables come from state alone, never from inputs.
  assign bus.in_ready  = (state == ST_IDLE) || (state == ST_LOAD_B) || (state == ST_LOAD_OP);
  assign bus.en        = (state == ST_EXEC) || (state == ST_HOLD);
  assign bus.out_valid = (state == ST_HOLD);
  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.op        = op_q;
  assign bus.res_out   = res_q;
  assign bus.flag_out  = flag_q;
  assign bus.err       = err_q;
  assign state_dbg     = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      res_q  <= '0;
      flag_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (clr) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      res_q  <= '0;
      flag_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_q   <= bus.data_in;
            state <= ST_LOAD_B;
          end
        end
        ST_LOAD_B: begin
          if (bus.in_valid) begin
            b_q   <= bus.data_in;
            state <= ST_LOAD_OP;
          end
        end
        ST_LOAD_OP: begin
          if (bus.in_valid) begin
            op_q <= bus.op_in;
            // A reserved opcode skips the units entirely and reports an error result.
            if (bus.op_in == OP_RSVD) begin
              state  <= ST_HOLD;
              err_q  <= 1'b1;
              res_q  <= '0;
              flag_q <= 1'b0;
            end else begin
              state <= ST_EXEC;
              cnt   <= CNT_INIT;
            end
          end
        end
        ST_EXEC: begin
          if (cnt == 4'd0) begin
            res_q  <= bus.res_in;
            flag_q <= bus.flag_in;
            state  <= ST_HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            state <= ST_IDLE;
            err_q <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// Random and directed operations against a behavioural function-unit model with an expected-result queue.
module tb_calc_operand_sequencer;
  import calc_pkg::*;

  localparam int WIDTH     = 4;
  localparam int RES_WIDTH = 8;
  localparam int EXEC      = 4;

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  logic   clr = 1'b0;
  logic   tie_one = 1'b0;
  state_t state_dbg;

  int tests = 0;
  int fails = 0;

  logic [RES_WIDTH+1:0] exp_q[$];

  calc_operand_sequencer_if #(.WIDTH(WIDTH), .RES_WIDTH(RES_WIDTH)) bus ();

  calc_operand_sequencer #(
    .WIDTH(WIDTH), .RES_WIDTH(RES_WIDTH), .EXEC_CYCLES(EXEC)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr), .bus(bus.slave), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference function units ----------------
  // Returns {flag, result}; result is the sign-extended signed value of the unit.
  function automatic logic [RES_WIDTH:0] unit(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                              input logic [2:0] o);
    int  ix = $signed(x);
    int  iy = $signed(y);
    int  r  = 0;
    logic f = 1'b0;
    case (o)
      3'd0: r = ix + iy;
      3'd1: r = ix - iy;
      3'd2: r = ix * iy;
      3'd3: r = $signed(x & y);
      3'd4: begin f = (ix != 0) && (iy != 0); r = int'(f); end
      3'd5: begin f = (ix != 0) || (iy != 0); r = int'(f); end
      3'd6: begin f = ix < iy; r = int'(f); end
      default: r = 0;
    endcase
    return {f, RES_WIDTH'(r)};
  endfunction

  logic [RES_WIDTH:0] unit_out;
  assign unit_out    = unit(bus.a, bus.b, bus.op);
  assign bus.res_in  = tie_one ? 8'h01 : (bus.en ? unit_out[RES_WIDTH-1:0] : '0);
  assign bus.flag_in = bus.en ? unit_out[RES_WIDTH] : 1'b0;

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic beat(input logic [WIDTH-1:0] d, input logic [2:0] o);
    int n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.data_in  = d;
    bus.op_in    = o;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("beat_ready", 64'(bus.in_ready), 64'd1);
    check_eq("en_load", 64'(bus.en), 64'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic consume();
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check_eq("consumed", {60'd0, bus.out_valid, bus.err, bus.in_ready, bus.en}, 64'b0010);
  endtask

  task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic [2:0] o,
                        input int hold, input bit do_consume);
    logic [RES_WIDTH:0]   u;
    logic [RES_WIDTH+1:0] exp;
    int lat;
    bit en_ok, stable_ok;
    u = unit(x, y, o);
    if (o == OP_RSVD)  exp = {1'b1, 1'b0, 8'h00};
    else if (tie_one)  exp = {1'b0, u[RES_WIDTH], 8'h01};
    else               exp = {1'b0, u};
    exp_q.push_back(exp);
    beat(x, 3'($urandom_range(0, 7)));
    beat(y, 3'($urandom_range(0, 7)));
    beat(4'($urandom_range(0, 15)), o);
    check_eq("operands", {52'd0, bus.a, bus.b, bus.op, 1'b0}, {52'd0, x, y, o, 1'b0});
    lat   = 0;
    en_ok = 1'b1;
    @(negedge clk);
    while (!bus.out_valid && lat < 40) begin
      if (!bus.en) en_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    check_eq("latency", 64'(lat), (o == OP_RSVD) ? 64'd0 : 64'(EXEC));
    check_eq("en_exec", 64'(en_ok && bus.en), 64'd1);
    exp = exp_q.pop_front();
    check_eq("result", {54'd0, bus.err, bus.flag_out, bus.res_out}, 64'(exp));
    stable_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.data_in   = 4'($urandom_range(0, 15));
      bus.op_in     = 3'($urandom_range(0, 7));
      bus.out_ready = 1'b0;
      @(negedge clk);
      if (!bus.out_valid || bus.in_ready || {bus.a, bus.b, bus.op} != {x, y, o} ||
          {bus.err, bus.flag_out, bus.res_out} != exp)
        stable_ok = 1'b0;
    end
    bus.in_valid = 1'b0;
    check_eq("hold_stable", 64'(stable_ok), 64'd1);
    if (do_consume) consume();
  endtask

  task automatic expect_cleared(input string tag);
    check_eq(tag, {40'd0, bus.in_ready, bus.en, bus.out_valid, bus.a, bus.b, bus.op,
                   bus.res_out, bus.flag_out, bus.err}, {40'd0, 1'b1, 23'd0});
  endtask

  task automatic pulse_clr(input string tag);
    bit quiet = 1'b1;
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    expect_cleared(tag);
    for (int i = 0; i < EXEC + 2; i++) begin
      @(negedge clk);
      if (bus.out_valid) quiet = 1'b0;
    end
    check_eq({tag, "_no_stale"}, 64'(quiet), 64'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.op_in     = '0;
    bus.out_ready = 1'b0;
    #12;
    expect_cleared("reset_values");
    @(negedge clk);
    rst = 1'b1;

    // Directed add with the unit result tied to 1.
    tie_one = 1'b1;
    run_op(4'd3, 4'hE, OP_ADD, 0, 1'b1);
    tie_one = 1'b0;

    // Logical and, false then true.
    run_op(4'h0, 4'h5, OP_LAND, 1, 1'b1);
    run_op(4'h2, 4'h5, OP_LAND, 1, 1'b1);

    // Reserved opcode.
    run_op(4'h7, 4'h1, OP_RSVD, 2, 1'b1);

    // Backpressure for 10 cycles, then A accepted the edge after consumption.
    run_op(4'h9, 4'h6, OP_MUL, 10, 1'b0);
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.data_in   = 4'hB;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check_eq("bp_consume", {60'd0, bus.out_valid, bus.in_ready, bus.a}, {60'd0, 2'b01, 4'h9});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check_eq("bp_a_loaded", {60'd0, bus.a}, 64'hB);
    pulse_clr("clr_load_b");

    // clr during EXEC.
    beat(4'h4, 3'd0);
    beat(4'h3, 3'd0);
    beat(4'h0, OP_SUB);
    pulse_clr("clr_exec");

    // clr during HOLD, for a reserved and a legal result.
    run_op(4'h1, 4'h2, OP_RSVD, 1, 1'b0);
    pulse_clr("clr_hold_rsvd");
    run_op(4'h5, 4'h5, OP_ADD, 1, 1'b0);
    pulse_clr("clr_hold");

    // Asynchronous reset in the middle of EXEC.
    beat(4'h6, 3'd0);
    beat(4'hA, 3'd0);
    beat(4'h0, OP_MUL);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    expect_cleared("rst_mid_exec");
    @(negedge clk);
    rst = 1'b1;
    run_op(4'h6, 4'hA, OP_MUL, 0, 1'b1);

    // Randomized operations.
    for (int k = 0; k < 40; k++) begin
      run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
             $urandom_range(0, 3), 1'b1);
    end

    check_eq("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    check_eq("watchdog", 64'd0, 64'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
